// File: rtl/rand_fill_ctrl.sv
// Seeds the Game-of-Life board from a 32-bit PRNG: warm-up, then four 8-bit
// threshold samples per PRNG word, written row-major into the board RAM.
module rand_fill_ctrl #(
    parameter int unsigned ROWS   = 32,
    parameter int unsigned COLS   = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WARMUP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [7:0]        density_i,
    output logic              prng_en_o,
    input  logic [31:0]       prng_val_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              wr_data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned Cells = ROWS * COLS;
    localparam int unsigned WarmW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WarmW-1:0]  WarmLast = WarmW'(WARMUP - 1);
    localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(Cells - 1);

    typedef enum logic [2:0] {StIdle, StWarm, StLoad, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [WarmW-1:0]  warm_q, warm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        dens_q, dens_d;
    logic [7:0]        sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            warm_q  <= '0;
            addr_q  <= '0;
            k_q     <= '0;
            word_q  <= '0;
            dens_q  <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            addr_q  <= addr_d;
            k_q     <= k_d;
            word_q  <= word_d;
            dens_q  <= dens_d;
        end
    end

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        addr_d  = addr_q;
        k_d     = k_q;
        word_d  = word_q;
        dens_d  = dens_q;
        unique case (state_q)
            StIdle: begin
                warm_d = '0;
                addr_d = '0;
                k_d    = '0;
                // abort wins over a simultaneous start
                if (start_i && !abort_i) begin
                    dens_d  = density_i;
                    state_d = StWarm;
                end
            end
            StWarm: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (warm_q == WarmLast) begin
                    state_d = StLoad;
                end else begin
                    warm_d = warm_q + 1'b1;
                end
            end
            StLoad: begin
                word_d  = prng_val_i;
                k_d     = '0;
                state_d = abort_i ? StIdle : StWrite;
            end
            StWrite: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else begin
                    addr_d = addr_q + 1'b1;
                    k_d    = k_q + 2'd1;
                    // the final cell ends the fill even mid-word
                    if (addr_q == AddrLast) begin
                        state_d = StDone;
                    end else if (k_q == 2'd3) begin
                        state_d = StLoad;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sample    = word_q[{k_q, 3'b000} +: 8];
        prng_en_o = (state_q == StWarm) || (state_q == StLoad);
        wr_en_o   = (state_q == StWrite);
        wr_addr_o = wr_en_o ? addr_q : '0;
        wr_data_o = wr_en_o && (sample < dens_q);
        busy_o    = (state_q == StWarm) || (state_q == StLoad) || (state_q == StWrite);
        done_o    = (state_q == StDone);
    end

endmodule

// File: tb/tb_rand_fill_ctrl.sv
// Scoreboard bench for rand_fill_ctrl: a 32x32 unit and a 3x3 unit, with
// expected writes and done timing queued by the stimulus and checked by a monitor.
module tb_rand_fill_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start0 = 0, abort0 = 0, prng_en0, wr_en0, wr_data0, busy0, done0;
    logic [7:0]  dens0 = 0;
    logic [31:0] pv0;
    logic [9:0]  wa0;
    logic        start1 = 0, abort1 = 0, prng_en1, wr_en1, wr_data1, busy1, done1;
    logic [7:0]  dens1 = 0;
    logic [31:0] pv1;
    logic [3:0]  wa1;

    logic [31:0] lfsr0 = 32'h1234_5678;
    logic        const_mode = 1'b0;

    logic [1:0] wr_en_v, wr_data_v, busy_v, prng_v, done_v;

    typedef struct {int unit; int addr; int data;} wr_t;
    typedef struct {int unit; int busy; int prng;} dn_t;
    wr_t exp_wr[$];
    dn_t exp_done[$];

    int tests = 0;
    int fails = 0;
    int busy_cnt[2];
    int prng_cnt[2];
    int done_seen[2];
    logic [1:0] busy_prev = 2'b00;
    // expected cell values by byte index: all dead, density 0xFF, density 0x10
    int pat[3][4] = '{'{0, 0, 0, 0}, '{1, 1, 0, 1}, '{0, 1, 0, 1}};

    always #5 clk = ~clk;

    rand_fill_ctrl #(.ROWS(32), .COLS(32), .ADDR_W(10), .WARMUP(16)) u_big (
        .clk(clk), .rst(rst), .start_i(start0), .abort_i(abort0), .density_i(dens0),
        .prng_en_o(prng_en0), .prng_val_i(pv0), .wr_en_o(wr_en0), .wr_addr_o(wa0),
        .wr_data_o(wr_data0), .busy_o(busy0), .done_o(done0)
    );

    rand_fill_ctrl #(.ROWS(3), .COLS(3), .ADDR_W(4), .WARMUP(1)) u_small (
        .clk(clk), .rst(rst), .start_i(start1), .abort_i(abort1), .density_i(dens1),
        .prng_en_o(prng_en1), .prng_val_i(pv1), .wr_en_o(wr_en1), .wr_addr_o(wa1),
        .wr_data_o(wr_data1), .busy_o(busy1), .done_o(done1)
    );

    assign pv0       = const_mode ? 32'h00FF_0010 : lfsr0;
    assign pv1       = 32'h00FF_0010;
    assign wr_en_v   = {wr_en1, wr_en0};
    assign wr_data_v = {wr_data1, wr_data0};
    assign busy_v    = {busy1, busy0};
    assign prng_v    = {prng_en1, prng_en0};
    assign done_v    = {done1, done0};

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    always @(posedge clk) if (prng_en0) lfsr0 <= xs(lfsr0);

    // Monitor: pops expected writes / done events as the DUTs present them.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            int a;
            wr_t e;
            dn_t d;
            a = (u == 0) ? int'(wa0) : int'(wa1);
            if (wr_en_v[u]) begin
                tests++;
                if (exp_wr.size() == 0) begin
                    fails++;
                    $display("FAIL wr_unexpected: unit %0d wrote addr %0d data %0d, required no write",
                             u, a, wr_data_v[u]);
                end else begin
                    e = exp_wr.pop_front();
                    if (e.unit != u || e.addr != a || e.data != int'(wr_data_v[u])) begin
                        fails++;
                        $display("FAIL wr: unit %0d addr %0d data %0d, required unit %0d addr %0d data %0d",
                                 u, a, wr_data_v[u], e.unit, e.addr, e.data);
                    end
                end
            end
            if (busy_v[u] && !busy_prev[u]) begin
                busy_cnt[u] = 1;
                prng_cnt[u] = prng_v[u] ? 1 : 0;
            end else if (busy_v[u]) begin
                busy_cnt[u]++;
                prng_cnt[u] += prng_v[u] ? 1 : 0;
            end
            busy_prev[u] = busy_v[u];
            if (done_v[u]) begin
                done_seen[u]++;
                tests++;
                if (exp_done.size() == 0) begin
                    fails++;
                    $display("FAIL done_unexpected: unit %0d pulsed done, required none", u);
                end else begin
                    d = exp_done.pop_front();
                    if (d.unit != u || d.busy != busy_cnt[u] || d.prng != prng_cnt[u]) begin
                        fails++;
                        $display("FAIL done: unit %0d busy %0d prng %0d, required unit %0d busy %0d prng %0d",
                                 u, busy_cnt[u], prng_cnt[u], d.unit, d.busy, d.prng);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic push_fill(input int u, input int n, input int mode);
        for (int i = 0; i < n; i++) exp_wr.push_back('{u, i, pat[mode][i % 4]});
    endtask

    task automatic start_unit(input int u, input logic [7:0] d);
        @(negedge clk);
        if (u == 0) begin dens0 = d; start0 = 1'b1; end
        else begin dens1 = d; start1 = 1'b1; end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int u, input int limit);
        int d0;
        int k;
        d0 = done_seen[u];
        k  = 0;
        while (done_seen[u] == d0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        if (done_seen[u] == d0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: unit %0d waited %0d cycles, required a done pulse", u, k);
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_prng_en", int'(prng_en0), 0);
        check("rst_wr_en", int'(wr_en0), 0);
        check("rst_wr_addr", int'(wa0), 0);
        check("rst_wr_data", int'(wr_data0), 0);
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_busy_small", int'(busy1), 0);
        @(negedge clk);
        rst = 1'b0;

        // density 0 on a free-running PRNG, with a stray start mid-WRITE
        const_mode = 1'b0;
        push_fill(0, 1024, 0);
        exp_done.push_back('{0, 16 + 1280, 16 + 256});
        start_unit(0, 8'h00);
        repeat (40) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        wait_done(0, 1500);

        // byte order with a fixed word, density 0xFF
        const_mode = 1'b1;
        push_fill(0, 1024, 1);
        exp_done.push_back('{0, 1296, 272});
        start_unit(0, 8'hFF);
        wait_done(0, 1500);

        // abort during the 10th write (busy-relative cycle 28)
        push_fill(0, 10, 1);
        start_unit(0, 8'hFF);
        repeat (28) @(posedge clk);
        #1 abort0 = 1'b1;
        @(posedge clk);
        #1 abort0 = 1'b0;
        check("abort_wr_en", int'(wr_en0), 0);
        check("abort_busy", int'(busy0), 0);
        check("abort_prng_en", int'(prng_en0), 0);
        repeat (30) @(posedge clk);
        #1 check("abort_busy_later", int'(busy0), 0);

        // refill from address 0 with fresh warm-up, density 0x10
        push_fill(0, 1024, 2);
        exp_done.push_back('{0, 1296, 272});
        start_unit(0, 8'h10);
        wait_done(0, 1500);

        // 3x3 board, warm-up 1: partial final group
        push_fill(1, 9, 1);
        exp_done.push_back('{1, 13, 4});
        start_unit(1, 8'hFF);
        wait_done(1, 100);

        // start and abort together in IDLE
        @(negedge clk);
        start0 = 1'b1;
        abort0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        abort0 = 1'b0;
        check("start_abort_busy", int'(busy0), 0);
        check("start_abort_prng_en", int'(prng_en0), 0);
        repeat (5) @(posedge clk);
        #1 check("start_abort_busy_later", int'(busy0), 0);

        // asynchronous reset mid-WRITE (addresses 0..8 seen before it)
        push_fill(0, 9, 1);
        start_unit(0, 8'hFF);
        repeat (28) @(posedge clk);
        #1 check("pre_rst_wr_en", int'(wr_en0), 1);
        #1 rst = 1'b1;
        #1;
        check("arst_wr_en", int'(wr_en0), 0);
        check("arst_wr_addr", int'(wa0), 0);
        check("arst_wr_data", int'(wr_data0), 0);
        check("arst_busy", int'(busy0), 0);
        check("arst_prng_en", int'(prng_en0), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_busy", int'(busy0), 0);
        check("post_rst_wr_en", int'(wr_en0), 0);

        check("wr_queue_left", exp_wr.size(), 0);
        check("done_queue_left", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
